// File: rtl/download_pkg.sv
// Shared definitions for the download write path.
// Holds width defaults, the word count and the FSM state encoding.
package download_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_HALF_W = 16;
    localparam int WORDS      = 2 ** DEF_ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/write_addr_gen_pair_packer.sv
// half_word_packer: holds the low half and assembles {hi, lo}.
// The packed word is registered and holds between writes.
module half_word_packer
    import download_pkg::*;
#(
    parameter int HALF_W = DEF_HALF_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lo_we,
    input  logic                hi_we,
    input  logic [HALF_W-1:0]   half,
    output logic [2*HALF_W-1:0] word
);

    logic [HALF_W-1:0] lo_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_reg <= '0;
            word   <= '0;
        end else begin
            if (lo_we) begin
                lo_reg <= half;
            end
            if (hi_we) begin
                word <= {half, lo_reg};
            end
        end
    end

endmodule

// File: rtl/write_addr_gen_pair.sv
// Packs 16-bit download halves into 32-bit memory writes.
// Optional DOWNLOAD_CHECKSUM_EN adds a running sum of accepted halves.
module write_addr_gen_pair
    import download_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int HALF_W = DEF_HALF_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [HALF_W-1:0]   in_data,
    output logic                in_ready,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [2*HALF_W-1:0] wr_data,
    output logic [ADDR_W:0]     half_addr,
    output logic                busy,
    output logic                done
`ifdef DOWNLOAD_CHECKSUM_EN
    ,
    output logic [HALF_W-1:0]   checksum
`endif
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t            state;
    logic [ADDR_W-1:0] word_addr;
    logic              half_sel;
    logic              xfer;
    logic              lo_we;
    logic              hi_we;
    logic              start_ok;

    assign xfer      = in_valid && in_ready;
    assign lo_we     = xfer && (state == LO);
    assign hi_we     = xfer && (state == HI);
    assign start_ok  = start && ((state == IDLE) || (state == DONE));
    assign half_addr = {word_addr, half_sel};

    half_word_packer #(
        .HALF_W (HALF_W)
    ) u_packer (
        .clk   (clk),
        .rst   (rst),
        .lo_we (lo_we),
        .hi_we (hi_we),
        .half  (in_data),
        .word  (wr_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            word_addr <= '0;
            half_sel  <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= LO;
                        word_addr <= '0;
                        half_sel  <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                LO: begin
                    if (xfer) begin
                        half_sel <= 1'b1;
                        state    <= HI;
                    end
                end
                HI: begin
                    if (xfer) begin
                        wr_addr  <= word_addr;
                        wr_en    <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    wr_en    <= 1'b0;
                    half_sel <= 1'b0;
                    // Last word wraps the counter and parks in DONE.
                    if (word_addr == LAST) begin
                        word_addr <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        word_addr <= word_addr + 1'b1;
                        in_ready  <= 1'b1;
                        state     <= LO;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DOWNLOAD_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else if (start_ok) begin
            checksum <= '0;
        end else if (xfer) begin
            checksum <= checksum + in_data;
        end
    end
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_write_addr_gen_pair.sv
// Directed bench for write_addr_gen_pair with a write scoreboard.
// Build with DOWNLOAD_CHECKSUM_EN to also check the checksum port.
module tb_write_addr_gen_pair;
    import download_pkg::*;

    localparam int AW = DEF_ADDR_W;
    localparam int HW = DEF_HALF_W;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            in_valid;
    logic [HW-1:0]   in_data;
    logic            in_ready;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [2*HW-1:0] wr_data;
    logic [AW:0]     half_addr;
    logic            busy;
    logic            done;
`ifdef DOWNLOAD_CHECKSUM_EN
    logic [HW-1:0]   checksum;
`endif

    int checks   = 0;
    int failures = 0;
    int nwrites  = 0;
    bit rnd      = 1'b0;
    logic prev_wr_en = 1'b0;
    logic [AW+2*HW-1:0] sb[$];
    logic [AW+2*HW-1:0] exp_e;

    write_addr_gen_pair dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .half_addr (half_addr),
        .busy      (busy),
`ifdef DOWNLOAD_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && wr_en) begin
            check("wr_en_single_cycle", 64'(prev_wr_en), 64'd0);
            check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_e = sb.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(exp_e[AW+2*HW-1:2*HW]));
                check("wr_data", 64'(wr_data), 64'(exp_e[2*HW-1:0]));
            end
            nwrites++;
        end
        prev_wr_en = wr_en;
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic xfer_half(input logic [HW-1:0] v);
        bit ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            in_data  = v;
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (in_valid && in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        in_valid = 1'b0;
        check("accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic send_pair(input int k, input logic [HW-1:0] lo,
                             input logic [HW-1:0] hi);
        xfer_half(lo);
        sb.push_back({AW'(k), hi, lo});
        xfer_half(hi);
    endtask

    task automatic run_full(input int ign_word);
        int base = nwrites;
        pulse_start();
        for (int k = 0; k < WORDS; k++) begin
            xfer_half(HW'(2 * k));
            if (k == 1) begin
                check("half_addr_progress", 64'(half_addr), 64'd3);
            end
            if (k == ign_word) begin
                check("ign_in_hi", 64'(half_addr), 64'({AW'(k), 1'b1}));
                pulse_start();
            end
            sb.push_back({AW'(k), HW'(2 * k + 1), HW'(2 * k)});
            xfer_half(HW'(2 * k + 1));
        end
        for (int n = 0; n < 10 && !done; n++) begin
            @(negedge clk);
        end
        check("full_done", 64'(done), 64'd1);
        check("full_busy", 64'(busy), 64'd0);
        check("full_ready", 64'(in_ready), 64'd0);
        check("full_writes", 64'(nwrites - base), 64'(WORDS));
        check("full_sb_empty", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clk);
        check("done_held", 64'({done, busy, in_ready}), 64'b100);
`ifdef DOWNLOAD_CHECKSUM_EN
        check("checksum_final", 64'(checksum), 64'h1FC0);
`endif
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #12;
        check("reset_outputs",
              64'({wr_en, wr_addr, wr_data, in_ready, busy, done, half_addr}),
              64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 64'({in_ready, busy, done}), 64'd0);

        pulse_start();
        check("start_status", 64'({in_ready, busy, done}), 64'b110);
        xfer_half(16'h1234);
        sb.push_back({AW'(0), 16'hABCD, 16'h1234});
        xfer_half(16'hABCD);
        check("basic_latency_wr_en", 64'(wr_en), 64'd1);
        check("basic_write_ready", 64'(in_ready), 64'd0);

        send_pair(1, 16'h0001, 16'h0002);
        xfer_half(16'h0003);
        check("pre_reset_writes", 64'(nwrites), 64'd2);
        check("pre_reset_sb", 64'(sb.size()), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrun_reset",
              64'({wr_en, wr_addr, wr_data, in_ready, busy, done, half_addr}),
              64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_idle", 64'({in_ready, busy, done}), 64'd0);

        pulse_start();
        send_pair(0, 16'h1111, 16'h2222);
        repeat (2) @(negedge clk);
        check("reset_new_sb", 64'(sb.size()), 64'd0);
        check("reset_new_writes", 64'(nwrites), 64'd3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        run_full(3);
        rnd = 1'b1;
        run_full(-1);
        rnd = 1'b0;

        pulse_start();
        check("restart_status", 64'({in_ready, busy, done}), 64'b110);
        check("restart_half_addr", 64'(half_addr), 64'd0);
`ifdef DOWNLOAD_CHECKSUM_EN
        check("checksum_cleared", 64'(checksum), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
